// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART-byte to Wishbone command bridge for debug/boot memory pokes.
//   'w' adr[4] dat[4] -> 32-bit Wishbone write, reply 'K' (0x4B)
//   'r' adr[4]        -> 32-bit Wishbone read,  reply dat[4] MSB first
//   Any other byte in IDLE is consumed and dropped.
// Ports:
//   clk, reset                          clock, async active-high reset
//   rx_data/rx_avail/rx_ack             uart receive handshake
//   tx_data/tx_wr/tx_busy               uart transmit handshake
//   wb_adr_o/wb_dat_o/wb_dat_i/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o/wb_ack_i
//                                       single-cycle Wishbone master
// Optional: define UART_WB_TIMEOUT_EN to abort a cycle after WB_TIMEOUT clocks
// without ack and reply 'T' (0x54).
module uart_wb_bridge #(
    parameter int unsigned WB_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_ADR = 3'd1;
    localparam logic [2:0] S_GET_DAT = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_TX      = 3'd4;

    localparam logic [7:0] OP_WR    = 8'h77;
    localparam logic [7:0] OP_RD    = 8'h72;
    localparam logic [7:0] RPL_OK   = 8'h4B;

    logic [2:0]  r_state,    w_state_nxt;
    logic [1:0]  r_cnt,      w_cnt_nxt;
    logic [1:0]  r_tx_last,  w_tx_last_nxt;
    logic        r_op_wr,    w_op_wr_nxt;
    logic [31:0] r_adr,      w_adr_nxt;
    logic [31:0] r_dat,      w_dat_nxt;
    logic        r_rx_ack,   w_rx_ack_nxt;
    logic        r_rx_ack_d;
    logic [7:0]  r_tx_data,  w_tx_data_nxt;
    logic        r_tx_wr,    w_tx_wr_nxt;
    logic        r_cyc,      w_cyc_nxt;
    logic        r_stb,      w_stb_nxt;
    logic        r_we,       w_we_nxt;
    logic [3:0]  r_sel,      w_sel_nxt;
    logic        w_rx_take;

`ifdef UART_WB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [7:0]  RPL_TO = 8'h54;
    logic [TO_W-1:0] r_to, w_to_nxt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (WB_TIMEOUT != 0);
`endif

    // A byte is taken only after rx_ack has been low for a full cycle, so the
    // uart has had time to retire the previous byte.
    assign w_rx_take = rx_avail && !r_rx_ack && !r_rx_ack_d &&
                       ((r_state == S_IDLE) || (r_state == S_GET_ADR) ||
                        (r_state == S_GET_DAT));

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tx_last_nxt = r_tx_last;
        w_op_wr_nxt   = r_op_wr;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_rx_ack_nxt  = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_tx_wr_nxt   = 1'b0;
        w_cyc_nxt     = r_cyc;
        w_stb_nxt     = r_stb;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
`ifdef UART_WB_TIMEOUT_EN
        w_to_nxt      = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_rx_take) begin
                    w_rx_ack_nxt = 1'b1;
                    if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                        w_op_wr_nxt = (rx_data == OP_WR);
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = S_GET_ADR;
                    end
                end
            end
            S_GET_ADR: begin
                if (w_rx_take) begin
                    w_rx_ack_nxt = 1'b1;
                    w_adr_nxt    = {r_adr[23:0], rx_data};
                    w_cnt_nxt    = 2'(r_cnt + 2'd1);
                    if (r_cnt == 2'd3) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = r_op_wr ? S_GET_DAT : S_WB;
                    end
                end
            end
            S_GET_DAT: begin
                if (w_rx_take) begin
                    w_rx_ack_nxt = 1'b1;
                    w_dat_nxt    = {r_dat[23:0], rx_data};
                    w_cnt_nxt    = 2'(r_cnt + 2'd1);
                    if (r_cnt == 2'd3) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_stb_nxt = 1'b1;
                    w_sel_nxt = 4'hF;
                    w_we_nxt  = r_op_wr;
                end else if (wb_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_sel_nxt   = 4'h0;
                    w_we_nxt    = 1'b0;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_TX;
                    // The reply is shifted out of the data register MSB first
                    if (r_op_wr) begin
                        w_dat_nxt     = {RPL_OK, 24'h0};
                        w_tx_last_nxt = 2'd0;
                    end else begin
                        w_dat_nxt     = wb_dat_i;
                        w_tx_last_nxt = 2'd3;
                    end
`ifdef UART_WB_TIMEOUT_EN
                end else if (r_to == TO_W'(WB_TIMEOUT - 1)) begin
                    w_cyc_nxt     = 1'b0;
                    w_stb_nxt     = 1'b0;
                    w_sel_nxt     = 4'h0;
                    w_we_nxt      = 1'b0;
                    w_cnt_nxt     = 2'd0;
                    w_dat_nxt     = {RPL_TO, 24'h0};
                    w_tx_last_nxt = 2'd0;
                    w_state_nxt   = S_TX;
                end else begin
                    w_to_nxt = TO_W'(r_to + 1'b1);
`endif
                end
            end
            S_TX: begin
                // Skipping the cycle after tx_wr covers a uart whose busy flag lags by one clock
                if (!tx_busy && !r_tx_wr) begin
                    w_tx_wr_nxt   = 1'b1;
                    w_tx_data_nxt = r_dat[31:24];
                    w_dat_nxt     = {r_dat[23:0], 8'h00};
                    w_cnt_nxt     = 2'(r_cnt + 2'd1);
                    if (r_cnt == r_tx_last) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_tx_last  <= 2'd0;
            r_op_wr    <= 1'b0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_rx_ack   <= 1'b0;
            r_rx_ack_d <= 1'b0;
            r_tx_data  <= 8'h0;
            r_tx_wr    <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
`ifdef UART_WB_TIMEOUT_EN
            r_to       <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_op_wr    <= w_op_wr_nxt;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_rx_ack   <= w_rx_ack_nxt;
            r_rx_ack_d <= r_rx_ack;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_wr    <= w_tx_wr_nxt;
            r_cyc      <= w_cyc_nxt;
            r_stb      <= w_stb_nxt;
            r_we       <= w_we_nxt;
            r_sel      <= w_sel_nxt;
`ifdef UART_WB_TIMEOUT_EN
            r_to       <= w_to_nxt;
`endif
        end
    end

    assign rx_ack   = r_rx_ack;
    assign tx_data  = r_tx_data;
    assign tx_wr    = r_tx_wr;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Debug/boot command bridge between the UART byte interface and the system Wishbone bus.
- Consumes received bytes from the uart core's rx handshake and decodes a small binary command protocol.
- Issues single 32-bit Wishbone master read/write cycles, then returns results through the uart core's tx handshake.
- Lets a host, or the system bench, poke memory such as DDR before the CPU runs.

Parameters:
- WB_TIMEOUT, 1023, Wishbone cycles to wait for ack before abort; used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- rx_data  input  8  received byte from uart
- rx_avail  input  1  rx_data valid; held until acked
- rx_ack  output  1  one-cycle pulse consuming the current rx byte
- tx_data  output  8  byte to transmit
- tx_wr  output  1  one-cycle pulse starting transmission
- tx_busy  input  1  uart transmitter busy
- wb_adr_o  output  32  Wishbone address
- wb_dat_o  output  32  Wishbone write data
- wb_dat_i  input  32  Wishbone read data
- wb_sel_o  output  4  byte select; always 4'hF during a cycle
- wb_we_o  output  1  write enable
- wb_cyc_o  output  1  cycle
- wb_stb_o  output  1  strobe
- wb_ack_i  input  1  acknowledge

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state IDLE; byte counter 0; address and data registers 0.
  - Reset mid-cycle drops cyc/stb immediately.
- Protocol (multi-byte fields big-endian, MSB first):
  - 'w' (0x77): addr[4], data[4] -> Wishbone write -> reply 0x4B ('K').
  - 'r' (0x72): addr[4] -> Wishbone read -> reply data[4], MSB first.
  - Any other byte in IDLE: acked and discarded, no reply.
- rx handshake:
  - rx_ack is pulsed for one cycle in the cycle after rx_avail is seen high in a receiving state (IDLE, GET_ADR, GET_DAT).
  - The next byte is not sampled until rx_ack has been low for one cycle, so each byte is consumed exactly once.
  - rx_avail is ignored in all other states; the byte waits in the uart.
- States:
  - IDLE: byte 'w' or 'r' -> latch opcode, cnt=0 -> GET_ADR.
  - GET_ADR: shift byte into adr: adr <= {adr[23:0], byte}. At cnt==3 -> GET_DAT if write, else WB.
  - GET_DAT: same shift into dat. At cnt==3 -> WB.
  - WB:
    - Assert cyc, stb, sel=F, we per opcode.
    - The cycle after wb_ack_i: deassert cyc/stb/we. Reads latch wb_dat_i into dat.
    - -> TX with 1 byte (write) or 4 bytes (read).
    - Minimum latency from last command byte ack to cyc: 1 clk.
  - TX:
    - When tx_busy==0 and no tx_wr in the previous cycle: tx_data = next byte, tx_wr = 1 for one clk.
    - The one-cycle guard covers the uart raising tx_busy one cycle late.
    - After the last byte -> IDLE. The bridge does not wait for tx_busy to fall before returning to IDLE.
- cnt is 2 bits, cleared on each state entry; wraps only by the state change.
- Wishbone ack arriving in the same cycle stb rises is legal; the cycle completes in 1 clk.
- wb_ack_i outside WB is ignored.
- Only one outstanding cycle; no pipelining.

Optional Feature:
- UART_WB_TIMEOUT_EN defined:
  - A counter of width clog2(WB_TIMEOUT+1) runs in WB.
  - If it reaches WB_TIMEOUT without ack: drop cyc/stb, send single byte 0x54 ('T') for both reads and writes, -> IDLE.
- Undefined: no counter, WB waits for ack indefinitely.

Test Plan:
- Write: bytes 77 00 00 10 00 DE AD BE EF, slave acks after 3 clk -> one cycle with we=1, adr=0x00001000, dat=0xDEADBEEF, sel=F; uart receives 0x4B.
- Read: 72 00 00 10 00, slave returns 0x12345678 with zero-wait ack -> uart receives 12 34 56 78 in order; cyc high exactly 1 clk.
- Junk: 67 00 then 72 00 00 00 04 -> 0x67 and 0x00 dropped, no tx; read of 0x00000004 proceeds normally.
- Backpressure: hold tx_busy high 500 clk during the read reply -> no tx_wr while busy; all 4 bytes sent once, none duplicated.
- Reset mid-WB: assert reset while cyc=1 -> cyc/stb/we/tx_wr/rx_ack 0 the same cycle; next command decodes from IDLE.
- UART_WB_TIMEOUT_EN with WB_TIMEOUT=15, no ack -> cyc drops after 15 clk; uart receives 0x54; the following write completes normally.
